// File: rtl/render_pkg.sv
// Shared types and default register map for the render command path.
package render_pkg;

    localparam int CMD_TEX_W = 7;
    localparam int CMD_X_W   = 9;
    localparam int CMD_Y_W   = 8;

    localparam logic [3:0] RENDER_ADDR_STAT = 4'd0;
    localparam logic [3:0] RENDER_ADDR_X    = 4'd1;
    localparam logic [3:0] RENDER_ADDR_Y    = 4'd2;
    localparam logic [3:0] RENDER_ADDR_TEX  = 4'd4;
    localparam logic [3:0] RENDER_ADDR_PLOT = 4'd6;

    typedef struct packed {
        logic                 fill;
        logic [CMD_TEX_W-1:0] tex;
        logic [CMD_X_W-1:0]   x;
        logic [CMD_Y_W-1:0]   y;
    } render_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_W_TEX,
        S_W_X,
        S_W_Y,
        S_W_PLOT,
        S_POLL,
        S_FIN
    } seq_state_e;

endpackage

// File: rtl/render_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; a full FIFO rejects pushes even when popping.
module render_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/render_cmd_sequencer.sv
// Avalon-MM master draining queued sprite/fill commands into the render slave,
// skipping register writes whose cached value already matches.
//
// state    | meaning
// IDLE     | wait for a queued command, pop it into cur
// LOAD     | pick the first register write the command needs
// W_TEX    | write texture register
// W_X      | write x register (sprites only)
// W_Y      | write y register (sprites only)
// W_PLOT   | write plot trigger, never skipped
// POLL     | read status until renderer not busy or poll limit hit
// FIN      | count the completed command
module render_cmd_sequencer
    import render_pkg::*;
#(
    parameter int         DEPTH      = 8,
    parameter int         X_W        = CMD_X_W,
    parameter int         Y_W        = CMD_Y_W,
    parameter int         TEX_W      = CMD_TEX_W,
    parameter logic [3:0] ADDR_X     = RENDER_ADDR_X,
    parameter logic [3:0] ADDR_Y     = RENDER_ADDR_Y,
    parameter logic [3:0] ADDR_TEX   = RENDER_ADDR_TEX,
    parameter logic [3:0] ADDR_PLOT  = RENDER_ADDR_PLOT,
    parameter logic [3:0] ADDR_STAT  = RENDER_ADDR_STAT,
    parameter int         POLL_DONE  = 1,
    parameter int         BUSY_BIT   = 0,
    parameter int         POLL_LIMIT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_fill,
    input  logic [TEX_W-1:0]       cmd_tex,
    input  logic [X_W-1:0]         cmd_x,
    input  logic [Y_W-1:0]         cmd_y,
    output logic [3:0]             m_address,
    output logic                   m_write,
    output logic [31:0]            m_writedata,
    output logic                   m_read,
    input  logic [31:0]            m_readdata,
    input  logic                   m_waitrequest,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            done_count,
    output logic                   timeout_err
);

    localparam int CMD_W = $bits(render_cmd_t);
    localparam int PC_W  = $clog2(POLL_LIMIT + 1);

    seq_state_e        state;
    seq_state_e        after_load, after_tex, after_x, wr_next;
    render_cmd_t       push_cmd, fifo_head, cur;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [TEX_W-1:0]  cur_tex, sh_tex;
    logic [X_W-1:0]    cur_x, sh_x;
    logic [Y_W-1:0]    cur_y, sh_y;
    logic              sh_tex_v, sh_x_v, sh_y_v;
    logic              need_tex, need_x, need_y;
    logic [3:0]        wr_addr;
    logic [31:0]       wr_data;
    logic [PC_W-1:0]   poll_cnt;
    logic              unused_readdata;

    assign push_cmd = '{fill: cmd_fill, tex: CMD_TEX_W'(cmd_tex),
                        x: CMD_X_W'(cmd_x), y: CMD_Y_W'(cmd_y)};
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;
    assign busy      = (state != S_IDLE) || !fifo_empty;
    assign unused_readdata = ^m_readdata;

    render_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .din   (push_cmd),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cur_tex  = TEX_W'(cur.tex);
    assign cur_x    = X_W'(cur.x);
    assign cur_y    = Y_W'(cur.y);
    assign need_tex = !sh_tex_v || (sh_tex != cur_tex);
    assign need_x   = !cur.fill && (!sh_x_v || (sh_x != cur_x));
    assign need_y   = !cur.fill && (!sh_y_v || (sh_y != cur_y));

    assign after_x    = need_y   ? S_W_Y   : S_W_PLOT;
    assign after_tex  = need_x   ? S_W_X   : after_x;
    assign after_load = need_tex ? S_W_TEX : after_tex;

    // Next write target and its bus values, so consecutive writes need no gap cycle.
    always_comb begin
        wr_next = S_W_PLOT;
        case (state)
            S_LOAD:  wr_next = after_load;
            S_W_TEX: wr_next = after_tex;
            S_W_X:   wr_next = after_x;
            default: wr_next = S_W_PLOT;
        endcase
        wr_addr = ADDR_PLOT;
        wr_data = '0;
        case (wr_next)
            S_W_TEX: begin wr_addr = ADDR_TEX; wr_data = 32'(cur_tex); end
            S_W_X:   begin wr_addr = ADDR_X;   wr_data = 32'(cur_x);   end
            S_W_Y:   begin wr_addr = ADDR_Y;   wr_data = 32'(cur_y);   end
            default: begin wr_addr = ADDR_PLOT; wr_data = '0;          end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur         <= '0;
            m_write     <= 1'b0;
            m_read      <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
            sh_tex      <= '0;
            sh_x        <= '0;
            sh_y        <= '0;
            sh_tex_v    <= 1'b0;
            sh_x_v      <= 1'b0;
            sh_y_v      <= 1'b0;
            poll_cnt    <= '0;
            done_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= fifo_head;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state       <= wr_next;
                    m_write     <= 1'b1;
                    m_address   <= wr_addr;
                    m_writedata <= wr_data;
                end
                S_W_TEX, S_W_X, S_W_Y: begin
                    if (!m_waitrequest) begin
                        if (state == S_W_TEX) begin sh_tex <= cur_tex; sh_tex_v <= 1'b1; end
                        if (state == S_W_X)   begin sh_x   <= cur_x;   sh_x_v   <= 1'b1; end
                        if (state == S_W_Y)   begin sh_y   <= cur_y;   sh_y_v   <= 1'b1; end
                        state       <= wr_next;
                        m_address   <= wr_addr;
                        m_writedata <= wr_data;
                    end
                end
                S_W_PLOT: begin
                    if (!m_waitrequest) begin
                        m_write <= 1'b0;
                        if (POLL_DONE != 0) begin
                            state     <= S_POLL;
                            m_read    <= 1'b1;
                            m_address <= ADDR_STAT;
                            poll_cnt  <= '0;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end
                S_POLL: begin
                    if (!m_waitrequest) begin
                        if (!m_readdata[BUSY_BIT]) begin
                            m_read <= 1'b0;
                            state  <= S_FIN;
                        end else if (poll_cnt == PC_W'(POLL_LIMIT - 1)) begin
                            // Renderer state is unknown after a timeout, so force full rewrites.
                            m_read      <= 1'b0;
                            timeout_err <= 1'b1;
                            sh_tex_v    <= 1'b0;
                            sh_x_v      <= 1'b0;
                            sh_y_v      <= 1'b0;
                            state       <= S_FIN;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    done_count <= done_count + 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_render_cmd_sequencer.sv
// Directed bench: write sequences, shadow skipping, stalls, FIFO full, reset, polling.
module tb_render_cmd_sequencer;
    import render_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr;
    logic        cmd_fill;
    logic [6:0]  cmd_tex;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic        v0, v1, v2, rdy0, rdy1, rdy2;
    logic [3:0]  a0, a1, a2;
    logic        w0, w1, w2, r0, r1, r2;
    logic [31:0] d0, d1, d2, rd0, rd1, rd2;
    logic        b0, b1, b2, t0, t1, t2;
    logic [3:0]  fc0, fc1, fc2;
    logic [15:0] dc0, dc1, dc2;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  overlap = 0;
    int  reads1 = 0, base1 = 0, reads2 = 0, writes2 = 0;
    wr_t wlog[$];

    assign rd0 = 32'd0;
    assign rd1 = {31'd0, (reads1 - base1) < 5};
    assign rd2 = 32'd1;

    render_cmd_sequencer #(.DEPTH(DEPTH), .POLL_DONE(0)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_fill(cmd_fill),
        .cmd_tex(cmd_tex), .cmd_x(cmd_x), .cmd_y(cmd_y), .m_address(a0), .m_write(w0),
        .m_writedata(d0), .m_read(r0), .m_readdata(rd0), .m_waitrequest(wr), .busy(b0),
        .fifo_count(fc0), .done_count(dc0), .timeout_err(t0));

    render_cmd_sequencer #(.DEPTH(DEPTH), .POLL_DONE(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_fill(cmd_fill),
        .cmd_tex(cmd_tex), .cmd_x(cmd_x), .cmd_y(cmd_y), .m_address(a1), .m_write(w1),
        .m_writedata(d1), .m_read(r1), .m_readdata(rd1), .m_waitrequest(wr), .busy(b1),
        .fifo_count(fc1), .done_count(dc1), .timeout_err(t1));

    render_cmd_sequencer #(.DEPTH(DEPTH), .POLL_DONE(1), .POLL_LIMIT(3)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_fill(cmd_fill),
        .cmd_tex(cmd_tex), .cmd_x(cmd_x), .cmd_y(cmd_y), .m_address(a2), .m_write(w2),
        .m_writedata(d2), .m_read(r2), .m_readdata(rd2), .m_waitrequest(wr), .busy(b2),
        .fifo_count(fc2), .done_count(dc2), .timeout_err(t2));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && w0 && !wr) wlog.push_back('{a0, d0, cyc});
        if (!rst && r1 && !wr && a1 == 4'd0) reads1 <= reads1 + 1;
        if (!rst && r2 && !wr && a2 == 4'd0) reads2 <= reads2 + 1;
        if (!rst && w2 && !wr) writes2 <= writes2 + 1;
        if ((w0 && r0) || (w1 && r1) || (w2 && r2)) overlap <= overlap + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic push(input int inst, input logic fill, input logic [6:0] tex,
                        input logic [8:0] x, input logic [7:0] y);
        @(negedge clk);
        cmd_fill = fill; cmd_tex = tex; cmd_x = x; cmd_y = y;
        v0 = (inst == 0); v1 = (inst == 1); v2 = (inst == 2);
        @(negedge clk);
        v0 = 0; v1 = 0; v2 = 0;
    endtask

    task automatic wait_idle(input int inst, input int budget);
        int n = 0;
        while (n < budget && ((inst == 0 && b0) || (inst == 1 && b1) || (inst == 2 && b2))) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((inst == 0 && b0) || (inst == 1 && b1) || (inst == 2 && b2)) begin
            failures++;
            $display("FAIL wait_idle inst=%0d busy still 1 after %0d cycles, required 0", inst, budget);
        end
    endtask

    task automatic test_reset;
        rst = 1; wr = 0; v0 = 0; v1 = 0; v2 = 0;
        cmd_fill = 0; cmd_tex = 0; cmd_x = 0; cmd_y = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({w0, r0, a0, d0} !== 38'd0) begin failures++;
            $display("FAIL reset_bus got w=%b r=%b a=%0d d=%0d required all 0", w0, r0, a0, d0); end
        checks++;
        if ({b0, fc0, dc0, t0} !== 22'd0) begin failures++;
            $display("FAIL reset_status got busy=%b fc=%0d dc=%0d to=%b required 0", b0, fc0, dc0, t0); end
        checks++;
        if ({rdy0, rdy1, rdy2} !== 3'b111) begin failures++;
            $display("FAIL reset_ready got %b required 111", {rdy0, rdy1, rdy2}); end
        rst = 0;
    endtask

    task automatic test_sprite;
        logic [35:0] exp_w [4] = '{{4'd4, 32'd5}, {4'd1, 32'd159}, {4'd2, 32'd119}, {4'd6, 32'd0}};
        wlog.delete();
        @(negedge clk);
        cmd_fill = 0; cmd_tex = 5; cmd_x = 159; cmd_y = 119; v0 = 1;
        @(posedge clk); #1; v0 = 0;
        checks++;
        if (fc0 !== 4'd1) begin failures++; $display("FAIL lat_edge0 fifo_count got %0d required 1", fc0); end
        @(posedge clk); #1;
        checks++;
        if (fc0 !== 4'd0 || b0 !== 1'b1 || w0 !== 1'b0) begin failures++;
            $display("FAIL lat_edge1 got fc=%0d busy=%b wr=%b required 0 1 0", fc0, b0, w0); end
        @(posedge clk); #1;
        checks++;
        if (w0 !== 1'b1 || a0 !== 4'd4 || d0 !== 32'd5) begin failures++;
            $display("FAIL lat_edge2 got wr=%b a=%0d d=%0d required 1 4 5", w0, a0, d0); end
        wait_idle(0, 50);
        checks++;
        if (wlog.size() != 4) begin failures++; $display("FAIL sprite_count got %0d required 4", wlog.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({wlog[i].a, wlog[i].d} !== exp_w[i]) begin failures++;
                    $display("FAIL sprite_w%0d got (%0d,%0d) required (%0d,%0d)", i, wlog[i].a, wlog[i].d,
                             exp_w[i][35:32], exp_w[i][31:0]); end
            end
            checks++;
            if (wlog[3].c - wlog[0].c != 3) begin failures++;
                $display("FAIL sprite_consecutive span got %0d required 3", wlog[3].c - wlog[0].c); end
        end
        checks++;
        if (dc0 !== 16'd1) begin failures++; $display("FAIL sprite_done got %0d required 1", dc0); end
    endtask

    task automatic test_cache;
        wlog.delete();
        push(0, 0, 7'd5, 9'd159, 8'd119);
        wait_idle(0, 50);
        checks++;
        if (wlog.size() != 1 || {wlog[0].a, wlog[0].d} !== {4'd6, 32'd0}) begin failures++;
            $display("FAIL cache_same got %0d writes required 1 write (6,0)", wlog.size()); end
        wlog.delete();
        push(0, 0, 7'd5, 9'd10, 8'd119);
        wait_idle(0, 50);
        checks++;
        if (wlog.size() != 2 || {wlog[0].a, wlog[0].d} !== {4'd1, 32'd10}
            || {wlog[1].a, wlog[1].d} !== {4'd6, 32'd0}) begin failures++;
            $display("FAIL cache_x got %0d writes required (1,10),(6,0)", wlog.size()); end
        checks++;
        if (dc0 !== 16'd3) begin failures++; $display("FAIL cache_done got %0d required 3", dc0); end
    endtask

    task automatic test_fill;
        wlog.delete();
        push(0, 1, 7'h6A, 9'd0, 8'd0);
        wait_idle(0, 50);
        checks++;
        if (wlog.size() != 2 || {wlog[0].a, wlog[0].d} !== {4'd4, 32'h6A}
            || {wlog[1].a, wlog[1].d} !== {4'd6, 32'd0}) begin failures++;
            $display("FAIL fill_writes got %0d writes required (4,0x6A),(6,0)", wlog.size()); end
        wlog.delete();
        push(0, 0, 7'd9, 9'd10, 8'd119);
        wait_idle(0, 50);
        checks++;
        if (wlog.size() != 2 || {wlog[0].a, wlog[0].d} !== {4'd4, 32'd9}
            || {wlog[1].a, wlog[1].d} !== {4'd6, 32'd0}) begin failures++;
            $display("FAIL fill_keeps_xy got %0d writes required (4,9),(6,0)", wlog.size()); end
        checks++;
        if (dc0 !== 16'd5) begin failures++; $display("FAIL fill_done got %0d required 5", dc0); end
    endtask

    task automatic test_stall;
        int n = 0;
        wlog.delete();
        wr = 1;
        push(0, 0, 7'd9, 9'd20, 8'd119);
        while (!w0 && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w0 !== 1'b1 || a0 !== 4'd1 || d0 !== 32'd20) begin failures++;
                $display("FAIL stall_hold%0d got wr=%b a=%0d d=%0d required 1 1 20", i, w0, a0, d0); end
            if (i == 3) wr = 0;
            @(negedge clk);
        end
        wait_idle(0, 50);
        checks++;
        if (wlog.size() != 2 || {wlog[0].a, wlog[0].d} !== {4'd1, 32'd20}
            || {wlog[1].a, wlog[1].d} !== {4'd6, 32'd0}) begin failures++;
            $display("FAIL stall_writes got %0d writes required (1,20),(6,0)", wlog.size()); end
    endtask

    task automatic test_full;
        int acc = 0;
        logic [6:0] t;
        wlog.delete();
        wr = 1;
        push(0, 1, 7'd1, 9'd0, 8'd0);
        repeat (3) @(negedge clk);
        cmd_fill = 1; cmd_x = 0; cmd_y = 0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            cmd_tex = 7'(20 + k);
            v0 = 1;
            if (rdy0) acc++;
            @(negedge clk);
        end
        v0 = 0;
        checks++;
        if (acc != DEPTH) begin failures++; $display("FAIL full_accepted got %0d required %0d", acc, DEPTH); end
        checks++;
        if (fc0 !== 4'(DEPTH) || rdy0 !== 1'b0) begin failures++;
            $display("FAIL full_ready got fc=%0d ready=%b required %0d 0", fc0, rdy0, DEPTH); end
        wr = 0;
        wait_idle(0, 300);
        checks++;
        if (wlog.size() != 2 * (DEPTH + 1)) begin failures++;
            $display("FAIL full_drain_count got %0d required %0d", wlog.size(), 2 * (DEPTH + 1)); end
        else begin
            for (int j = 0; j <= DEPTH; j++) begin
                t = (j == 0) ? 7'd1 : 7'(19 + j);
                checks++;
                if ({wlog[2*j].a, wlog[2*j].d} !== {4'd4, 25'd0, t}
                    || {wlog[2*j+1].a, wlog[2*j+1].d} !== {4'd6, 32'd0}) begin failures++;
                    $display("FAIL full_order%0d got (%0d,%0d) required (4,%0d)", j, wlog[2*j].a, wlog[2*j].d, t); end
            end
        end
        checks++;
        if (dc0 !== 16'd15 || fc0 !== 4'd0) begin failures++;
            $display("FAIL full_done got dc=%0d fc=%0d required 15 0", dc0, fc0); end
    endtask

    task automatic test_back_to_back;
        wlog.delete();
        @(negedge clk);
        cmd_fill = 0; cmd_tex = 11; cmd_x = 100; cmd_y = 50; v0 = 1;
        @(negedge clk);
        cmd_tex = 12; cmd_x = 101; cmd_y = 51;
        @(posedge clk); #1; v0 = 0;
        checks++;
        if (fc0 !== 4'd1) begin failures++; $display("FAIL b2b_push_pop fifo_count got %0d required 1", fc0); end
        wait_idle(0, 60);
        checks++;
        if (wlog.size() != 8) begin failures++; $display("FAIL b2b_count got %0d required 8", wlog.size()); end
        else begin
            checks++;
            if ({wlog[0].d, wlog[1].d, wlog[2].d, wlog[4].d, wlog[5].d, wlog[6].d}
                !== {32'd11, 32'd100, 32'd50, 32'd12, 32'd101, 32'd51}) begin failures++;
                $display("FAIL b2b_data got %0d %0d %0d %0d required 11 100 50 12", wlog[0].d, wlog[1].d,
                         wlog[2].d, wlog[4].d); end
            checks++;
            if (wlog[7].c - wlog[3].c != 7) begin failures++;
                $display("FAIL b2b_period got %0d cycles required 7", wlog[7].c - wlog[3].c); end
        end
        checks++;
        if (dc0 !== 16'd17) begin failures++; $display("FAIL b2b_done got %0d required 17", dc0); end
    endtask

    task automatic test_reset_mid;
        wr = 1;
        push(0, 0, 7'd3, 9'd30, 8'd40);
        push(0, 0, 7'd4, 9'd31, 8'd41);
        repeat (2) @(negedge clk);
        checks++;
        if (w0 !== 1'b1) begin failures++; $display("FAIL rstmid_pre write got %b required 1", w0); end
        rst = 1;
        @(posedge clk); #1;
        checks++;
        if ({w0, r0, b0, fc0, dc0} !== 23'd0) begin failures++;
            $display("FAIL rstmid_clear got wr=%b rd=%b busy=%b fc=%0d dc=%0d required 0", w0, r0, b0, fc0, dc0); end
        rst = 0; wr = 0;
        wlog.delete();
        push(0, 0, 7'd9, 9'd20, 8'd119);
        wait_idle(0, 50);
        checks++;
        if (wlog.size() != 4 || {wlog[0].a, wlog[0].d} !== {4'd4, 32'd9} || {wlog[1].a, wlog[1].d} !== {4'd1, 32'd20}
            || {wlog[2].a, wlog[2].d} !== {4'd2, 32'd119}) begin failures++;
            $display("FAIL rstmid_shadows got %0d writes required full rewrite of 4", wlog.size()); end
        checks++;
        if (dc0 !== 16'd1) begin failures++; $display("FAIL rstmid_done got %0d required 1", dc0); end
    endtask

    task automatic test_poll;
        base1 = reads1;
        push(1, 0, 7'd5, 9'd159, 8'd119);
        wait_idle(1, 100);
        checks++;
        if (reads1 - base1 != 6) begin failures++; $display("FAIL poll_reads got %0d required 6", reads1 - base1); end
        checks++;
        if (dc1 !== 16'd1 || t1 !== 1'b0) begin failures++;
            $display("FAIL poll_done got dc=%0d to=%b required 1 0", dc1, t1); end
    endtask

    task automatic test_timeout;
        push(2, 0, 7'd5, 9'd1, 8'd2);
        wait_idle(2, 100);
        checks++;
        if (reads2 != 3 || t2 !== 1'b1 || dc2 !== 16'd1) begin failures++;
            $display("FAIL timeout_first got reads=%0d to=%b dc=%0d required 3 1 1", reads2, t2, dc2); end
        checks++;
        if (writes2 != 4) begin failures++; $display("FAIL timeout_w1 got %0d writes required 4", writes2); end
        push(2, 0, 7'd5, 9'd1, 8'd2);
        wait_idle(2, 100);
        checks++;
        if (writes2 != 8 || reads2 != 6 || dc2 !== 16'd2 || t2 !== 1'b1) begin failures++;
            $display("FAIL timeout_rewrite got writes=%0d reads=%0d dc=%0d required 8 6 2", writes2, reads2, dc2); end
        checks++;
        if (overlap != 0) begin failures++; $display("FAIL strobe_overlap got %0d cycles required 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_sprite();
        test_cache();
        test_fill();
        test_stall();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_poll();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
